// File: rtl/vga_sel_pkg.sv
// Shared types and helpers for the frame-aligned VGA source selector.
package vga_sel_pkg;

    typedef enum logic [1:0] {
        LIVE    = 2'd0,
        WAIT_VS = 2'd1,
        BLANK   = 2'd2
    } sel_state_t;

    // Fixed screen indices of the original three-screen game
    localparam int SRC_START = 0;
    localparam int SRC_PLAY  = 1;
    localparam int SRC_END   = 2;

    // Widest request vector the helpers accept; callers zero-extend into it
    localparam int MAX_SRC = 32;

    // True when exactly one bit of the request vector is set
    function automatic logic onehot_valid(input logic [MAX_SRC-1:0] v);
        return (v != '0) && ((v & (v - MAX_SRC'(1))) == '0);
    endfunction

    // Index of the lowest set bit; only meaningful when onehot_valid() holds
    function automatic logic [4:0] onehot_to_idx(input logic [MAX_SRC-1:0] v);
        logic [4:0] idx;
        idx = '0;
        for (int i = MAX_SRC - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = 5'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/vga_src_mux.sv
// Combinational N-way selector: picks the W-bit slice of source i_sel out of a
// packed per-source bus. Indices beyond N_SRC-1 return all zeros.
module vga_src_mux #(
    parameter int N_SRC = 3,
    parameter int W     = 1,
    parameter int SEL_W = $clog2(N_SRC)
) (
    input  logic [N_SRC*W-1:0] i_bus,
    input  logic [SEL_W-1:0]   i_sel,
    output logic [W-1:0]       o_slice
);

    // Index-driven slice of the packed bus
    always_comb begin
        o_slice = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (i_sel == SEL_W'(i)) begin
                o_slice = i_bus[i*W +: W];
            end
        end
    end

endmodule

// File: rtl/vga_frame_switch.sv
// N-source VGA output selector. A change of screen request is only honoured at
// a frame boundary (VSYNC falling edge of the source currently on the pins),
// followed by a programmable number of black frames, so the monitor never sees
// a torn frame. A dead source is abandoned after a cycle timeout.
//
//  state   | meaning
//  --------+---------------------------------------------------------------
//  LIVE    | pins follow source active_sel
//  WAIT_VS | switch pending; old source still on the pins until its VSYNC
//          | falls or the timeout expires (black if entered from BLANK)
//  BLANK   | new source's syncs on the pins, RGB black, counting its frames
module vga_frame_switch
    import vga_sel_pkg::*;
#(
    parameter int N_SRC        = 3,
    parameter int COLOR_W      = 1,
    parameter int BLANK_FRAMES = 1,
    parameter int TIMEOUT_CYC  = 1_100_000
) (
    input  logic                       Clk_40mhz,
    input  logic                       RST,
    input  logic [N_SRC-1:0]           Game_status,
    input  logic [N_SRC*COLOR_W-1:0]   src_VGA_red,
    input  logic [N_SRC*COLOR_W-1:0]   src_VGA_green,
    input  logic [N_SRC*COLOR_W-1:0]   src_VGA_blue,
    input  logic [N_SRC-1:0]           src_HSYNC_sig,
    input  logic [N_SRC-1:0]           src_VSYNC_sig,
    output logic                       HSYNC_Sig_out,
    output logic                       VSYNC_Sig_out,
    output logic [COLOR_W-1:0]         VGA_red_out,
    output logic [COLOR_W-1:0]         VGA_green_out,
    output logic [COLOR_W-1:0]         VGA_blue_out,
    output logic [$clog2(N_SRC)-1:0]   active_sel,
    output logic                       switch_busy,
    output logic                       status_err
);

    localparam int SEL_W = $clog2(N_SRC);
    localparam int PIX_W = 3 * COLOR_W + 2;
    localparam int TO_W  = $clog2(TIMEOUT_CYC) + 1;
    localparam int BF_W  = 4;

    sel_state_t         r_state;
    sel_state_t         w_state_nxt;
    logic [SEL_W-1:0]   r_active_sel;
    logic [SEL_W-1:0]   w_active_sel_nxt;
    logic [SEL_W-1:0]   r_pending;
    logic [SEL_W-1:0]   w_pending_nxt;
    logic [SEL_W-1:0]   w_target;
    logic [BF_W-1:0]    r_blank_cnt;
    logic [BF_W-1:0]    w_blank_cnt_nxt;
    logic [TO_W-1:0]    r_to_cnt;
    logic [TO_W-1:0]    w_to_cnt_nxt;
    logic               r_blank_hold;
    logic               w_blank_hold_nxt;
    logic               r_vs_prev;
    logic               r_status_err;

    logic               r_hs;
    logic               r_vs;
    logic [COLOR_W-1:0] r_red;
    logic [COLOR_W-1:0] r_green;
    logic [COLOR_W-1:0] r_blue;

    logic [MAX_SRC-1:0] w_status_ext;
    logic               w_req_valid;
    logic [SEL_W-1:0]   w_req_idx;

    logic [N_SRC*PIX_W-1:0] w_pix_bus;
    logic [PIX_W-1:0]   w_live_pix;
    logic [COLOR_W-1:0] w_live_red;
    logic [COLOR_W-1:0] w_live_green;
    logic [COLOR_W-1:0] w_live_blue;
    logic               w_live_hs;
    logic               w_live_vs;
    logic               w_vs_next_src;
    logic               w_vs_fall;
    logic               w_timeout;
    logic               w_rgb_blank;
    logic               w_busy;

    // Request decode: only a one-hot code names a source
    assign w_status_ext = MAX_SRC'(Game_status);
    assign w_req_valid  = onehot_valid(w_status_ext);
    assign w_req_idx    = SEL_W'(onehot_to_idx(w_status_ext));

    // Per-source pixel word {red, green, blue, hsync, vsync}
    for (genvar g = 0; g < N_SRC; g++) begin : g_pack
        assign w_pix_bus[g*PIX_W +: PIX_W] = {src_VGA_red[g*COLOR_W +: COLOR_W],
                                              src_VGA_green[g*COLOR_W +: COLOR_W],
                                              src_VGA_blue[g*COLOR_W +: COLOR_W],
                                              src_HSYNC_sig[g],
                                              src_VSYNC_sig[g]};
    end

    vga_src_mux #(
        .N_SRC (N_SRC),
        .W     (PIX_W),
        .SEL_W (SEL_W)
    ) u_live_mux (
        .i_bus   (w_pix_bus),
        .i_sel   (r_active_sel),
        .o_slice (w_live_pix)
    );

    // Edge-detect path looks at the source that will be active next cycle, so
    // a change of active_sel reloads vs_prev from the new source and no false
    // edge is seen across the switch.
    vga_src_mux #(
        .N_SRC (N_SRC),
        .W     (1),
        .SEL_W (SEL_W)
    ) u_edge_mux (
        .i_bus   (src_VSYNC_sig),
        .i_sel   (w_active_sel_nxt),
        .o_slice (w_vs_next_src)
    );

    assign w_live_red   = w_live_pix[PIX_W-1 -: COLOR_W];
    assign w_live_green = w_live_pix[PIX_W-1-COLOR_W -: COLOR_W];
    assign w_live_blue  = w_live_pix[COLOR_W+1 -: COLOR_W];
    assign w_live_hs    = w_live_pix[1];
    assign w_live_vs    = w_live_pix[0];

    assign w_vs_fall = r_vs_prev & ~w_live_vs;
    assign w_timeout = (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));

    // State register
    always_ff @(posedge Clk_40mhz or posedge RST) begin
        if (RST) begin
            r_state <= LIVE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and switch bookkeeping
    always_comb begin
        w_state_nxt      = r_state;
        w_active_sel_nxt = r_active_sel;
        w_pending_nxt    = r_pending;
        w_blank_cnt_nxt  = r_blank_cnt;
        w_to_cnt_nxt     = r_to_cnt;
        w_blank_hold_nxt = r_blank_hold;
        w_target         = r_pending;
        unique case (r_state)
            LIVE: begin
                if (w_req_valid && (w_req_idx != r_active_sel)) begin
                    w_pending_nxt    = w_req_idx;
                    w_to_cnt_nxt     = '0;
                    w_blank_hold_nxt = 1'b0;
                    w_state_nxt      = WAIT_VS;
                end
            end
            WAIT_VS: begin
                w_to_cnt_nxt = r_to_cnt + TO_W'(1);
                if (w_req_valid && (w_req_idx == r_active_sel)) begin
                    w_to_cnt_nxt     = '0;
                    w_blank_hold_nxt = 1'b0;
                    w_state_nxt      = LIVE;
                end else begin
                    // A request landing on the boundary cycle wins over the old pending
                    if (w_req_valid) begin
                        w_target = w_req_idx;
                    end
                    w_pending_nxt = w_target;
                    if (w_vs_fall || w_timeout) begin
                        w_active_sel_nxt = w_target;
                        w_to_cnt_nxt     = '0;
                        w_blank_hold_nxt = 1'b0;
                        if (BLANK_FRAMES == 0) begin
                            w_state_nxt = LIVE;
                        end else begin
                            w_blank_cnt_nxt = BF_W'(BLANK_FRAMES);
                            w_state_nxt     = BLANK;
                        end
                    end
                end
            end
            BLANK: begin
                if (w_req_valid && (w_req_idx != r_active_sel)) begin
                    w_pending_nxt    = w_req_idx;
                    w_to_cnt_nxt     = '0;
                    w_blank_hold_nxt = 1'b1;
                    w_state_nxt      = WAIT_VS;
                end else if (w_vs_fall) begin
                    if (r_blank_cnt <= BF_W'(1)) begin
                        w_blank_cnt_nxt = '0;
                        w_state_nxt     = LIVE;
                    end else begin
                        w_blank_cnt_nxt = r_blank_cnt - BF_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = LIVE;
            end
        endcase
    end

    // Output decode: blanking follows the state being entered so the first
    // live pixel lines up with the frame edge that ends BLANK
    always_comb begin
        w_rgb_blank = 1'b0;
        w_busy      = (r_state != LIVE);
        unique case (w_state_nxt)
            BLANK:   w_rgb_blank = 1'b1;
            WAIT_VS: w_rgb_blank = w_blank_hold_nxt;
            default: w_rgb_blank = 1'b0;
        endcase
    end

    // Switch bookkeeping registers and VSYNC history
    always_ff @(posedge Clk_40mhz or posedge RST) begin
        if (RST) begin
            r_active_sel <= SEL_W'(SRC_START);
            r_pending    <= SEL_W'(SRC_START);
            r_blank_cnt  <= '0;
            r_to_cnt     <= '0;
            r_blank_hold <= 1'b0;
            r_vs_prev    <= 1'b1;
        end else begin
            r_active_sel <= w_active_sel_nxt;
            r_pending    <= w_pending_nxt;
            r_blank_cnt  <= w_blank_cnt_nxt;
            r_to_cnt     <= w_to_cnt_nxt;
            r_blank_hold <= w_blank_hold_nxt;
            r_vs_prev    <= w_vs_next_src;
        end
    end

    // Sticky flag for malformed screen requests
    always_ff @(posedge Clk_40mhz or posedge RST) begin
        if (RST) begin
            r_status_err <= 1'b0;
        end else if (!w_req_valid) begin
            r_status_err <= 1'b1;
        end
    end

    // Registered pin drivers: syncs idle high, RGB black in reset
    always_ff @(posedge Clk_40mhz or posedge RST) begin
        if (RST) begin
            r_hs    <= 1'b1;
            r_vs    <= 1'b1;
            r_red   <= '0;
            r_green <= '0;
            r_blue  <= '0;
        end else begin
            r_hs    <= w_live_hs;
            r_vs    <= w_live_vs;
            r_red   <= w_rgb_blank ? '0 : w_live_red;
            r_green <= w_rgb_blank ? '0 : w_live_green;
            r_blue  <= w_rgb_blank ? '0 : w_live_blue;
        end
    end

    assign HSYNC_Sig_out = r_hs;
    assign VSYNC_Sig_out = r_vs;
    assign VGA_red_out   = r_red;
    assign VGA_green_out = r_green;
    assign VGA_blue_out  = r_blue;
    assign active_sel    = r_active_sel;
    assign switch_busy   = w_busy;
    assign status_err    = r_status_err;

endmodule

// File: tb/tb_vga_frame_switch.sv
// Event scoreboard for vga_frame_switch. The observed word is
// {hsync, vsync, active_sel, busy, r, g, b, status_err}; every change of it is
// popped against the next hand-computed expected event (value and cycle).
module tb_vga_frame_switch;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] gs;
    logic [2:0] src_red;
    logic [2:0] src_green;
    logic [2:0] src_blue;
    logic [2:0] src_hs;
    logic [2:0] src_vs;
    logic       hs_out;
    logic       vs_out;
    logic       red_out;
    logic       green_out;
    logic       blue_out;
    logic [1:0] sel_out;
    logic       busy_out;
    logic       err_out;

    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    bit         mon_en = 1'b0;
    bit         prev_ok = 1'b0;
    logic [8:0] prev_obs;

    int         q_cyc[$];
    logic [8:0] q_t[$];
    string      q_name[$];

    logic [8:0] w_obs;
    assign w_obs = {hs_out, vs_out, sel_out, busy_out, red_out, green_out, blue_out, err_out};

    vga_frame_switch #(
        .N_SRC        (3),
        .COLOR_W      (1),
        .BLANK_FRAMES (2),
        .TIMEOUT_CYC  (40)
    ) dut (
        .Clk_40mhz     (clk),
        .RST           (rst),
        .Game_status   (gs),
        .src_VGA_red   (src_red),
        .src_VGA_green (src_green),
        .src_VGA_blue  (src_blue),
        .src_HSYNC_sig (src_hs),
        .src_VSYNC_sig (src_vs),
        .HSYNC_Sig_out (hs_out),
        .VSYNC_Sig_out (vs_out),
        .VGA_red_out   (red_out),
        .VGA_green_out (green_out),
        .VGA_blue_out  (blue_out),
        .active_sel    (sel_out),
        .switch_busy   (busy_out),
        .status_err    (err_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [8:0] tp(input logic hs, input logic vs, input logic [1:0] sel,
                                      input logic busy, input logic [2:0] rgb, input logic err);
        return {hs, vs, sel, busy, rgb, err};
    endfunction

    task automatic expect_ev(input int c, input logic [8:0] t, input string nm);
        q_cyc.push_back(c);
        q_t.push_back(t);
        q_name.push_back(nm);
    endtask

    // One-cycle VSYNC low pulse on source i; optionally expect the two output events
    task automatic pulse(input int i, input bit chk, input logic [8:0] t1,
                         input logic [8:0] t2, input string nm);
        int c;
        @(negedge clk);
        c = cyc;
        if (chk) begin
            expect_ev(c + 1, t1, {nm, "_a"});
            expect_ev(c + 2, t2, {nm, "_b"});
        end
        src_vs[i] = 1'b0;
        @(negedge clk);
        src_vs[i] = 1'b1;
    endtask

    // Monitor: every change of the observed word consumes one expected event
    always @(negedge clk) begin
        if (mon_en) begin
            if (!prev_ok || (w_obs != prev_obs)) begin
                total++;
                if (q_t.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_change: got %b at cyc=%0d, none expected", w_obs, cyc);
                end else begin
                    if ((w_obs != q_t[0]) || ((q_cyc[0] >= 0) && (q_cyc[0] != cyc))) begin
                        bad++;
                        $display("FAIL %s: got %b at cyc=%0d, expected %b at cyc=%0d",
                                 q_name[0], w_obs, cyc, q_t[0], q_cyc[0]);
                    end
                    void'(q_cyc.pop_front());
                    void'(q_t.pop_front());
                    void'(q_name.pop_front());
                end
            end
            prev_obs = w_obs;
            prev_ok  = 1'b1;
        end
    end

    initial begin
        int c;
        // src0 red, src1 green, src2 blue; HSYNC levels 1/0/1 identify the source
        rst       = 1'b1;
        gs        = 3'b001;
        src_red   = 3'b001;
        src_green = 3'b010;
        src_blue  = 3'b100;
        src_hs    = 3'b101;
        src_vs    = 3'b111;

        repeat (2) @(negedge clk);
        expect_ev(-1, tp(1, 1, 0, 0, 3'b000, 0), "reset_state");
        mon_en = 1'b1;
        repeat (2) @(negedge clk);
        c = cyc;
        expect_ev(c + 1, tp(1, 1, 0, 0, 3'b100, 0), "live0");
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Request 1, then reset mid-wait with request still applied
        c = cyc;
        expect_ev(c + 1, tp(1, 1, 0, 1, 3'b100, 0), "req1");
        gs = 3'b010;
        repeat (2) @(negedge clk);
        c = cyc;
        expect_ev(c + 1, tp(1, 1, 0, 0, 3'b000, 0), "rst_mid");
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        c = cyc;
        expect_ev(c + 1, tp(1, 1, 0, 1, 3'b100, 0), "post_rst_wait");
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Frame-aligned switch 0 -> 1 with two black frames
        pulse(0, 1, tp(1, 0, 1, 1, 3'b000, 0), tp(0, 1, 1, 1, 3'b000, 0), "sw0to1");
        repeat (3) @(negedge clk);
        pulse(0, 0, '0, '0, "old_src_vs");
        repeat (2) @(negedge clk);
        pulse(1, 1, tp(0, 0, 1, 1, 3'b000, 0), tp(0, 1, 1, 1, 3'b000, 0), "blank1");
        repeat (4) @(negedge clk);
        pulse(1, 1, tp(0, 0, 1, 0, 3'b010, 0), tp(0, 1, 1, 0, 3'b010, 0), "live1");
        repeat (3) @(negedge clk);

        // Retarget 0 then 2 before the edge: single switch lands on 2
        @(negedge clk);
        c = cyc;
        expect_ev(c + 1, tp(0, 1, 1, 1, 3'b010, 0), "req0");
        gs = 3'b001;
        repeat (3) @(negedge clk);
        gs = 3'b100;
        repeat (3) @(negedge clk);
        pulse(1, 1, tp(0, 0, 2, 1, 3'b000, 0), tp(1, 1, 2, 1, 3'b000, 0), "retarget2");
        repeat (2) @(negedge clk);

        // Request during BLANK: stays black through WAIT_VS, switches to 0
        gs = 3'b001;
        repeat (3) @(negedge clk);
        pulse(2, 1, tp(1, 0, 0, 1, 3'b000, 0), tp(1, 1, 0, 1, 3'b000, 0), "sw2to0");
        repeat (2) @(negedge clk);
        pulse(0, 1, tp(1, 0, 0, 1, 3'b000, 0), tp(1, 1, 0, 1, 3'b000, 0), "blank0");
        repeat (2) @(negedge clk);
        pulse(0, 1, tp(1, 0, 0, 0, 3'b100, 0), tp(1, 1, 0, 0, 3'b100, 0), "live0b");
        repeat (2) @(negedge clk);

        // Abort: 0 -> 1 -> 0 before an edge
        @(negedge clk);
        c = cyc;
        expect_ev(c + 1, tp(1, 1, 0, 1, 3'b100, 0), "req1b");
        gs = 3'b010;
        repeat (2) @(negedge clk);
        c = cyc;
        expect_ev(c + 1, tp(1, 1, 0, 0, 3'b100, 0), "abort");
        gs = 3'b001;
        repeat (2) @(negedge clk);
        pulse(0, 1, tp(1, 0, 0, 0, 3'b100, 0), tp(1, 1, 0, 0, 3'b100, 0), "abort_vs");
        repeat (2) @(negedge clk);

        // Edge and new request in the same cycle: goes to the new request
        @(negedge clk);
        c = cyc;
        expect_ev(c + 1, tp(1, 1, 0, 1, 3'b100, 0), "req1c");
        gs = 3'b010;
        repeat (2) @(negedge clk);
        c = cyc;
        expect_ev(c + 1, tp(1, 0, 2, 1, 3'b000, 0), "simul_a");
        expect_ev(c + 2, tp(1, 1, 2, 1, 3'b000, 0), "simul_b");
        gs = 3'b100;
        src_vs[0] = 1'b0;
        @(negedge clk);
        src_vs[0] = 1'b1;
        repeat (2) @(negedge clk);
        pulse(2, 1, tp(1, 0, 2, 1, 3'b000, 0), tp(1, 1, 2, 1, 3'b000, 0), "blank2");
        repeat (2) @(negedge clk);
        pulse(2, 1, tp(1, 0, 2, 0, 3'b001, 0), tp(1, 1, 2, 0, 3'b001, 0), "live2");
        repeat (2) @(negedge clk);

        // Dead source 2: forced switch to 1 exactly 40 cycles after the request edge
        @(negedge clk);
        c = cyc;
        expect_ev(c + 1, tp(1, 1, 2, 1, 3'b001, 0), "req1d");
        expect_ev(c + 41, tp(1, 1, 1, 1, 3'b000, 0), "timeout_sw");
        expect_ev(c + 42, tp(0, 1, 1, 1, 3'b000, 0), "timeout_new1");
        gs = 3'b010;
        repeat (10) @(negedge clk);
        pulse(1, 0, '0, '0, "inactive_vs");
        repeat (34) @(negedge clk);
        pulse(1, 1, tp(0, 0, 1, 1, 3'b000, 0), tp(0, 1, 1, 1, 3'b000, 0), "blank1b");
        repeat (2) @(negedge clk);
        pulse(1, 1, tp(0, 0, 1, 0, 3'b010, 0), tp(0, 1, 1, 0, 3'b010, 0), "live1b");
        repeat (2) @(negedge clk);

        // Malformed requests: sticky error, no retarget
        @(negedge clk);
        c = cyc;
        expect_ev(c + 1, tp(0, 1, 1, 0, 3'b010, 1), "err011");
        gs = 3'b011;
        repeat (3) @(negedge clk);
        gs = 3'b000;
        repeat (3) @(negedge clk);
        gs = 3'b010;
        repeat (3) @(negedge clk);
        pulse(1, 1, tp(0, 0, 1, 0, 3'b010, 1), tp(0, 1, 1, 0, 3'b010, 1), "err_sticky");
        repeat (2) @(negedge clk);

        // Reset is the only thing that clears the error flag
        @(negedge clk);
        c = cyc;
        expect_ev(c + 1, tp(1, 1, 0, 0, 3'b000, 0), "rst_clears_err");
        #2 rst = 1'b1;
        repeat (4) @(negedge clk);

        while (q_t.size() > 0) begin
            total++;
            bad++;
            $display("FAIL %s: event never observed, expected %b at cyc=%0d",
                     q_name[0], q_t[0], q_cyc[0]);
            void'(q_cyc.pop_front());
            void'(q_t.pop_front());
            void'(q_name.pop_front());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
